// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and output-stage state encodings.
package fifo_pkg;

  localparam int unsigned GRAY_W = 32;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } stage_e;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b = g;
    for (int i = 1; i < GRAY_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read pointer (binary + Gray) and registered empty flag against the synchronized write pointer.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 9
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                fetch,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbinnext;
  logic [PTR_W-1:0] rgraynext;

  assign rbinnext  = rbin + PTR_W'(fetch);
  assign rgraynext = PTR_W'(bin2gray(GRAY_W'(rbinnext)));
  assign raddr     = rbin[ADDRSIZE-1:0];

  // Empty is judged on the post-fetch pointer so the last word sets rempty on its own edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side controller: pointer/empty tracking plus a 2-entry FWFT valid/ready output stage.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 9,
  parameter int unsigned DATASIZE = 128
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready
);

  stage_e              state;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] skid;
  logic                pop;
  logic                fetch;

  assign pop    = m_valid && m_ready;
  assign fetch  = !rempty && ((state != S2) || pop);
  assign m_data = head;

  rptr_empty #(
    .ADDRSIZE(ADDRSIZE)
  ) u_rptr_empty (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .fetch   (fetch),
    .rq2_wptr(rq2_wptr),
    .rptr    (rptr),
    .raddr   (raddr),
    .rempty  (rempty)
  );

  // Output stage: head is what the consumer sees, skid absorbs one word of backpressure.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= S0;
      head    <= '0;
      skid    <= '0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        S0: begin
          if (fetch) begin
            head    <= rdata;
            state   <= S1;
            m_valid <= 1'b1;
          end
        end
        S1: begin
          if (fetch && !pop) begin
            skid  <= rdata;
            state <= S2;
          end else if (fetch && pop) begin
            head <= rdata;
          end else if (pop) begin
            state   <= S0;
            m_valid <= 1'b0;
          end
        end
        S2: begin
          if (pop && fetch) begin
            head <= skid;
            skid <= rdata;
          end else if (pop) begin
            head  <= skid;
            state <= S1;
          end
        end
        default: begin
          state   <= S0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: memory/write-side model with a scoreboard of written words.
module tb_fifo_rd_stream;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [DW-1:0] mem [4];
  logic [AW:0]   wbin;
  logic [DW-1:0] sb [$];
  int            total = 0;
  int            bad   = 0;

  fifo_rd_stream #(
    .ADDRSIZE(AW),
    .DATASIZE(DW)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rq2_wptr(rq2_wptr),
    .rptr    (rptr),
    .raddr   (raddr),
    .rdata   (rdata),
    .rempty  (rempty),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 rclk = ~rclk;

  assign rdata = mem[raddr];

  function automatic logic [AW:0] g3(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write side: store the word, advance the write pointer, expect it at the stream output.
  task automatic wr(input logic [DW-1:0] w);
    mem[wbin[AW-1:0]] = w;
    wbin     = wbin + 1'b1;
    rq2_wptr = g3(wbin);
    sb.push_back(w);
  endtask

  // One clock: score a handshake if one is about to occur, then advance to the next negedge.
  task automatic cyc();
    logic [DW-1:0] e;
    if (m_valid && m_ready) begin
      check("sb_has_word", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("stream_data", 32'(m_data), 32'(e));
      end
    end
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic drain(input int maxc, input string tag);
    m_ready = 1'b1;
    for (int n = 0; n < maxc && sb.size() != 0; n++) cyc();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int last;
    foreach (mem[i]) mem[i] = '0;
    rrst_n   = 1'b0;
    m_ready  = 1'b0;
    wbin     = '0;
    rq2_wptr = '0;

    // Reset state
    @(negedge rclk);
    @(negedge rclk);
    check("rst_rptr",   32'(rptr),    32'd0);
    check("rst_raddr",  32'(raddr),   32'd0);
    check("rst_rempty", 32'(rempty),  32'd1);
    check("rst_valid",  32'(m_valid), 32'd0);
    check("rst_data",   32'(m_data),  32'd0);
    rrst_n = 1'b1;
    cyc(); cyc(); cyc();
    check("idle_rempty", 32'(rempty),  32'd1);
    check("idle_valid",  32'(m_valid), 32'd0);
    check("idle_rptr",   32'(rptr),    32'd0);

    // Single word and first-word latency
    wr(16'h00A5);
    cyc();
    check("lat1_valid",  32'(m_valid), 32'd0);
    check("lat1_rempty", 32'(rempty),  32'd0);
    cyc();
    check("lat2_valid",  32'(m_valid), 32'd1);
    check("lat2_data",   32'(m_data),  32'h00A5);
    check("lat2_rempty", 32'(rempty),  32'd1);
    check("lat2_rptr",   32'(rptr),    32'(g3(3'd1)));
    m_ready = 1'b1;
    cyc();
    check("single_valid",  32'(m_valid), 32'd0);
    check("single_rempty", 32'(rempty),  32'd1);
    check("single_rptr",   32'(rptr),    32'(g3(3'd1)));
    m_ready = 1'b0;

    // Backpressure: stage fills, head holds, one word stays in memory
    wr(16'd1); wr(16'd2); wr(16'd3);
    repeat (5) cyc();
    check("bp_valid",  32'(m_valid), 32'd1);
    check("bp_data",   32'(m_data),  32'd1);
    check("bp_rempty", 32'(rempty),  32'd0);
    repeat (2) begin
      cyc();
      check("bp_hold", 32'(m_data), 32'd1);
    end
    m_ready = 1'b1;
    repeat (3) begin
      check("bp_stream_valid", 32'(m_valid), 32'd1);
      cyc();
    end
    check("bp_done_valid", 32'(m_valid), 32'd0);
    check("bp_done_sb",    32'(sb.size()), 32'd0);

    // Full memory, then pointer wrap
    for (int i = 0; i < 4; i++) wr(16'h0010 + 16'(i));
    drain(20, "full_drain");
    check("wrap_rempty", 32'(rempty), 32'd1);
    check("wrap_rptr",   32'(rptr),   32'd0);
    check("wrap_raddr",  32'(raddr),  32'd0);
    for (int i = 0; i < 4; i++) wr(16'h0020 + 16'(i));
    drain(20, "refill_drain");
    check("refill_rptr",   32'(rptr),   32'(g3(3'd4)));
    check("refill_rempty", 32'(rempty), 32'd1);

    // Throughput: one write per cycle must stream out with no gaps
    m_ready = 1'b1;
    first   = -1;
    last    = -1;
    for (int i = 0; i < 20; i++) begin
      if (i < 12) wr(16'h0100 + 16'(i));
      if (m_valid) begin
        if (first < 0) first = i;
        last = i;
      end
      cyc();
    end
    check("tput_span", 32'(last - first), 32'd11);
    check("tput_sb",   32'(sb.size()),    32'd0);

    // Asynchronous reset with the stage full
    m_ready = 1'b0;
    wr(16'h0031); wr(16'h0032); wr(16'h0033);
    repeat (5) cyc();
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_data",  32'(m_data),  32'h0031);
    #2;
    rrst_n = 1'b0;
    #1;
    check("arst_valid",  32'(m_valid), 32'd0);
    check("arst_data",   32'(m_data),  32'd0);
    check("arst_rptr",   32'(rptr),    32'd0);
    check("arst_raddr",  32'(raddr),   32'd0);
    check("arst_rempty", 32'(rempty),  32'd1);
    sb.delete();
    wbin     = '0;
    rq2_wptr = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
    wr(16'h0055);
    drain(10, "restart_drain");
    check("restart_rptr",   32'(rptr),   32'(g3(3'd1)));
    check("restart_rempty", 32'(rempty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
